fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Parametrised fetch program-counter generator with an integrated return-address stack (RAS). It sits at the head of the fetch stage and drives the instruction-cache address. Relative to the single-source PC it generalises address width, increment stride, reset vector and the number of stall sources, and it adds call/return prediction. Redirect priority is fixed: recover, then stall, then return, then jump/call, then sequential.

## Interface

Parameters:
- ADDR_W, 16: PC width in bits.
- STRIDE, 1: sequential increment, modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.
- RAS_DEPTH, 4: RAS entries. Power of two, 2..16.
- N_STALL, 3: number of stall request sources.

Ports:
- clk  in  1  clock. All state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  N_STALL  stall requests (pc, pipeline, memory). Any bit set holds the PC.
- recover_valid  in  1  misprediction or bubble recovery.
- recover_pc  in  ADDR_W  PC to resume from on recovery.
- jump_valid  in  1  taken jump or branch.
- jump_target  in  ADDR_W  jump destination.
- call_valid  in  1  jump is a call. Only meaningful with jump_valid.
- ret_valid  in  1  return. Next PC comes from the RAS top.
- pc_out  out  ADDR_W  current fetch PC (registered).
- pc_plus_one  out  ADDR_W  pc_out + STRIDE (combinational).
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ret_miss  out  1  registered, one-cycle pulse when a return popped an empty RAS.

## Operation

- Define adv = no bit of stall is set.
- Next-PC selection, highest priority first:
  - recover_valid: pc_out <= recover_pc. Overrides stall. RAS is not modified.
  - !adv: pc_out and the RAS hold.
  - ret_valid with RAS non-empty: pc_out <= RAS top, then pop.
  - ret_valid with RAS empty: pc_out <= pc_plus_one, ret_miss <= 1.
  - jump_valid: pc_out <= jump_target. If call_valid is also set, push pc_plus_one.
  - otherwise: pc_out <= pc_plus_one.
- call_valid without jump_valid is ignored.
- ret_valid together with jump_valid: the return wins and the jump is dropped.
- If the return is taken, any simultaneous call push is dropped.
- RAS is a circular buffer with top pointer tp and occupancy count cnt (0..RAS_DEPTH):
  - Push: write entry[tp+1], tp <= tp+1, cnt <= min(cnt+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry. Pointers wrap modulo RAS_DEPTH and no error is raised.
  - Pop: tp <= tp-1, cnt <= cnt-1.
- ras_empty = (cnt==0). ras_full = (cnt==RAS_DEPTH). Both derive from registers.
- Arithmetic: all PC sums are truncated to ADDR_W, so PC wraps from 2^ADDR_W-STRIDE to 0.

## Timing

- Reset, asynchronous on assertion, state takes effect immediately:
  - pc_out = RESET_PC, cnt = 0, tp = 0, ret_miss = 0.
  - RAS contents are don't-care.
- While reset is held, pc_out stays RESET_PC and inputs are ignored.
- A reset asserted mid-stall or mid-recovery wins.
- Latency: any input takes effect in pc_out one clock after the sampling edge. pc_plus_one follows pc_out combinationally in the same cycle.
- The RAS top used by a return is the value before that edge's push/pop.
- ret_miss is high for exactly the one cycle after the offending edge. It is cleared on every other edge, including stalled edges.
- No handshake. The block samples every input every cycle, so callers must hold jump, call and ret asserted only for the advancing cycle they intend.

## Test plan

- Reset and sequential: RESET_PC=0x0100, STRIDE=1, no stimulus for 3 clocks after reset falls -> pc_out = 0x0100, 0x0101, 0x0102, 0x0103. Asserting reset mid-cycle -> pc_out returns to 0x0100 immediately, before the next edge.
- Stall and recover precedence: pc_out=0x0010, stall=3'b100 for 2 clocks -> pc_out stays 0x0010. Then stall=3'b001 with recover_valid and recover_pc=0x0200 -> pc_out = 0x0200 next cycle.
- Call/return:
  - At pc_out=0x0020, jump to 0x0300 with call_valid -> pc_out=0x0300, ras_empty=0.
  - Later ret_valid -> pc_out=0x0021, ras_empty=1.
- RAS overflow: RAS_DEPTH=4, five calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1. Five returns give 0x51, 0x41, 0x31, 0x21, then on the fifth return ret_miss=1 and pc_out = pc_plus_one.
- Conflicts:
  - ret_valid and jump_valid together with RAS top 0x0051 -> pc_out=0x0051 and no push occurs.
  - call_valid alone -> cnt unchanged.
  - ret_valid while stalled -> no pop.
- Wrap-around: ADDR_W=16, STRIDE=2, pc_out=0xFFFE -> next pc_out=0x0000. A call at 0xFFFE pushes 0x0000.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch program-counter generator with a return-address stack.
// The next PC is chosen by fixed priority: recover, stall, return, jump/call,
// sequential. The RAS is a circular buffer that overwrites its oldest entry
// when a call arrives while it is full.
module fetch_pc_gen #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned STRIDE    = 1,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned N_STALL   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_STALL-1:0] stall,
   input  logic              recover_valid,
   input  logic [ADDR_W-1:0] recover_pc,
   input  logic              jump_valid,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              call_valid,
   input  logic              ret_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic [ADDR_W-1:0] pc_plus_one,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ret_miss
);

   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [ADDR_W-1:0] STRIDE_V  = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] RESET_V   = ADDR_W'(RESET_PC);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(RAS_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  tp_q, tp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ret_miss_q, ret_miss_d;

   // RAS storage has no reset: its contents only matter where cnt says so.
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic              ras_we;
   logic [PTR_W-1:0]  ras_wptr;
   logic [ADDR_W-1:0] ras_wdata;

   logic              adv;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] ras_top;

   assign adv     = ~|stall;
   assign pc_inc  = pc_q + STRIDE_V;   // truncates, so the PC wraps to 0
   assign ras_top = ras_q[tp_q];

   // Next-PC selection and RAS pointer update, highest priority first.
   always_comb begin
      pc_d       = pc_q;
      tp_d       = tp_q;
      cnt_d      = cnt_q;
      ret_miss_d = 1'b0;
      ras_we     = 1'b0;
      ras_wptr   = tp_q + PTR_ONE;
      ras_wdata  = pc_inc;

      if (recover_valid) begin
         // Recovery beats stall and leaves the RAS alone.
         pc_d = recover_pc;
      end else if (adv) begin
         if (ret_valid) begin
            // A return drops any jump/call sampled on the same edge.
            if (cnt_q != '0) begin
               pc_d  = ras_top;
               tp_d  = tp_q - PTR_ONE;
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               pc_d       = pc_inc;
               ret_miss_d = 1'b1;
            end
         end else if (jump_valid) begin
            pc_d = jump_target;
            if (call_valid) begin
               // When full, tp+1 lands on the oldest entry and overwrites it.
               ras_we = 1'b1;
               tp_d   = tp_q + PTR_ONE;
               if (cnt_q != CNT_MAX)
                  cnt_d = cnt_q + CNT_ONE;
            end
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   // PC, RAS pointers and miss pulse; reset takes effect immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_V;
         tp_q       <= '0;
         cnt_q      <= '0;
         ret_miss_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         tp_q       <= tp_d;
         cnt_q      <= cnt_d;
         ret_miss_q <= ret_miss_d;
      end
   end

   // RAS entry write on a call push; blocked while reset is held.
   always_ff @(posedge clk) begin
      if (ras_we && !reset)
         ras_q[ras_wptr] <= ras_wdata;
   end

   assign pc_out      = pc_q;
   assign pc_plus_one = pc_inc;
   assign ras_empty   = (cnt_q == '0);
   assign ras_full    = (cnt_q == CNT_MAX);
   assign ret_miss    = ret_miss_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: two instances (STRIDE 1 and 2) share the inputs.
// A reference model predicts each cycle's outputs into a scoreboard queue,
// which is popped and compared one time unit after the clock edge.
module tb_fetch_pc_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  stall;
   logic        recover_valid;
   logic [15:0] recover_pc;
   logic        jump_valid;
   logic [15:0] jump_target;
   logic        call_valid;
   logic        ret_valid;

   logic [15:0] pc0, pp0, pc1, pp1;
   logic        e0, f0, m0, e1, f1, m1;

   always #5 clk = ~clk;

   fetch_pc_gen #(.ADDR_W(16), .STRIDE(1), .RESET_PC(16'h0100), .RAS_DEPTH(4), .N_STALL(3)) u_dut0 (
      .clk(clk), .reset(reset), .stall(stall),
      .recover_valid(recover_valid), .recover_pc(recover_pc),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .call_valid(call_valid), .ret_valid(ret_valid),
      .pc_out(pc0), .pc_plus_one(pp0), .ras_empty(e0), .ras_full(f0), .ret_miss(m0));

   fetch_pc_gen #(.ADDR_W(16), .STRIDE(2), .RESET_PC(16'hFFFC), .RAS_DEPTH(4), .N_STALL(3)) u_dut1 (
      .clk(clk), .reset(reset), .stall(stall),
      .recover_valid(recover_valid), .recover_pc(recover_pc),
      .jump_valid(jump_valid), .jump_target(jump_target),
      .call_valid(call_valid), .ret_valid(ret_valid),
      .pc_out(pc1), .pc_plus_one(pp1), .ras_empty(e1), .ras_full(f1), .ret_miss(m1));

   typedef struct packed {
      logic [15:0] pc0, pp0, pc1, pp1;
      logic        e0, f0, m0, e1, f1, m1;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: a plain stack that shifts out its oldest entry.
   logic [15:0] m_pc   [2];
   logic [15:0] m_stk  [2][4];
   int          m_n    [2];
   logic        m_miss [2];
   logic [15:0] stride [2] = '{16'd1, 16'd2};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.pc0 = m_pc[0];  e.pp0 = m_pc[0] + stride[0];
      e.pc1 = m_pc[1];  e.pp1 = m_pc[1] + stride[1];
      e.e0 = (m_n[0] == 0); e.f0 = (m_n[0] == 4); e.m0 = m_miss[0];
      e.e1 = (m_n[1] == 0); e.f1 = (m_n[1] == 4); e.m1 = m_miss[1];
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_size", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk("pc0", pc0, e.pc0);  chk("pp0", pp0, e.pp0);
      chk("empty0", e0, e.e0); chk("full0", f0, e.f0); chk("miss0", m0, e.m0);
      chk("pc1", pc1, e.pc1);  chk("pp1", pp1, e.pp1);
      chk("empty1", e1, e.e1); chk("full1", f1, e.f1); chk("miss1", m1, e.m1);
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic [15:0] inc;
         inc       = m_pc[k] + stride[k];
         m_miss[k] = 1'b0;
         if (recover_valid) begin
            m_pc[k] = recover_pc;
         end else if (stall == 3'b000) begin
            if (ret_valid) begin
               if (m_n[k] > 0) begin
                  m_n[k]--;
                  m_pc[k] = m_stk[k][m_n[k]];
               end else begin
                  m_pc[k]   = inc;
                  m_miss[k] = 1'b1;
               end
            end else if (jump_valid) begin
               if (call_valid) begin
                  if (m_n[k] == 4) begin
                     for (int j = 0; j < 3; j++) m_stk[k][j] = m_stk[k][j+1];
                     m_n[k] = 3;
                  end
                  m_stk[k][m_n[k]] = inc;
                  m_n[k]++;
               end
               m_pc[k] = jump_target;
            end else begin
               m_pc[k] = inc;
            end
         end
      end
   endtask

   task automatic model_reset();
      m_pc[0] = 16'h0100;
      m_pc[1] = 16'hFFFC;
      for (int k = 0; k < 2; k++) begin
         m_n[k]    = 0;
         m_miss[k] = 1'b0;
      end
   endtask

   // Called one time unit after a posedge: drive, predict, clock, compare.
   task automatic cyc(input logic [2:0] st, input logic rv, input logic [15:0] rpc,
                      input logic jv, input logic [15:0] jt, input logic cv, input logic retv);
      stall = st; recover_valid = rv; recover_pc = rpc;
      jump_valid = jv; jump_target = jt; call_valid = cv; ret_valid = retv;
      model_step();
      push_exp();
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle();                    cyc(3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0); endtask
   task automatic rec(input logic [15:0] p); cyc(3'b000, 1'b1, p,     1'b0, 16'h0, 1'b0, 1'b0); endtask
   task automatic call(input logic [15:0] t);cyc(3'b000, 1'b0, 16'h0, 1'b1, t,     1'b1, 1'b0); endtask
   task automatic ret();                     cyc(3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1); endtask

   // Asynchronous reset: outputs must change before any clock edge.
   task automatic async_reset();
      reset = 1'b1;
      #1;
      model_reset();
      push_exp();
      check_out();
   endtask

   initial begin
      reset = 1'b0; stall = '0; recover_valid = 1'b0; recover_pc = '0;
      jump_valid = 1'b0; jump_target = '0; call_valid = 1'b0; ret_valid = 1'b0;
      #1;
      async_reset();
      // Still held across an edge: PC must stay at the reset vector.
      @(posedge clk); #1;
      push_exp(); check_out();
      reset = 1'b0;

      // Sequential fetch; instance 1 also wraps 0xFFFE -> 0x0000.
      repeat (3) idle();

      // Reset asserted mid-cycle.
      async_reset();
      reset = 1'b0;
      idle();

      // Stall holds, recover overrides stall.
      rec(16'h0010);
      cyc(3'b100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc(3'b100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc(3'b001, 1'b1, 16'h0200, 1'b0, 16'h0, 1'b0, 1'b0);

      // Call then return.
      rec(16'h0020);
      call(16'h0300);
      idle(); idle();
      ret();

      // Overflow: five calls, five returns, last one misses.
      for (int i = 1; i <= 5; i++) begin
         rec(16'(i * 16'h0010));
         call(16'h1000);
      end
      repeat (5) ret();
      idle();

      // Conflicts.
      rec(16'h0050);
      call(16'h0700);
      cyc(3'b000, 1'b0, 16'h0, 1'b1, 16'h0900, 1'b1, 1'b1);  // ret+jump+call
      cyc(3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);     // call alone
      rec(16'h0060);
      call(16'h0800);
      cyc(3'b010, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);     // stalled ret
      ret();
      ret();                                                  // miss
      cyc(3'b001, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);     // miss clears

      // Wrap-around of sequential and pushed addresses.
      rec(16'hFFFE);
      idle();
      rec(16'hFFFE);
      call(16'h0400);
      ret();

      // Random mix.
      for (int n = 0; n < 400; n++) begin
         logic [2:0]  st;
         st = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         cyc(st, ($urandom_range(0, 11) == 0), 16'($urandom),
             ($urandom_range(0, 2) == 0), 16'($urandom),
             ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
